// File: rtl/dmem_responder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_responder_if : request/response bus between memory stage and responder
// Rev 1.0
// ----------------------------------------------------------------------------
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_responder : single-outstanding data memory with fixed access latency
// Rev 1.0
// ----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  wire logic        clk,
  input  wire logic        reset,
  dmem_responder_if.slave  bus
);

  localparam int         c_DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_BUSY = 2'd1;
  localparam logic [1:0] c_ST_RESP = 2'd2;

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $error("dmem_responder: LATENCY must be within 1..15");
  end

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_error_q, resp_error_d;

  logic [31:0] mem_q [c_DEPTH];

  logic                  w_accept;
  logic                  w_access;
  logic                  w_acc_write;
  logic [31:0]           w_acc_addr;
  logic [31:0]           w_acc_wdata;
  logic                  w_acc_err;
  logic [DEPTH_LOG2-1:0] w_acc_idx;
  logic                  w_mem_we;

  // With LATENCY=1 the access happens on the accepting edge, so the
  // operands come straight from the bus instead of the latched copies.
  always_comb begin
    w_accept    = (state_q == c_ST_IDLE) && bus.req_valid;
    w_access    = ((state_q == c_ST_BUSY) && (cnt_q == 4'd0)) ||
                  (w_accept && (LATENCY == 1));
    w_acc_write = (state_q == c_ST_IDLE) ? bus.req_write : write_q;
    w_acc_addr  = (state_q == c_ST_IDLE) ? bus.req_addr  : addr_q;
    w_acc_wdata = (state_q == c_ST_IDLE) ? bus.req_wdata : wdata_q;
    w_acc_err   = (w_acc_addr[1:0] != 2'b00) ||
                  (w_acc_addr[31:DEPTH_LOG2+2] != '0);
    w_acc_idx   = w_acc_addr[DEPTH_LOG2+1:2];
    w_mem_we    = w_access && w_acc_write && !w_acc_err;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;

    case (state_q)
      c_ST_IDLE: begin
        if (w_accept) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = c_CNT_INIT;
          state_d = (LATENCY == 1) ? c_ST_RESP : c_ST_BUSY;
        end
      end
      c_ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = c_ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      c_ST_RESP: begin
        if (bus.resp_ready) begin
          state_d      = c_ST_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = c_ST_IDLE;
    endcase

    if (w_access) begin
      resp_valid_d = 1'b1;
      resp_error_d = w_acc_err;
      resp_rdata_d = (w_acc_write || w_acc_err) ? 32'd0 : mem_q[w_acc_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= c_ST_IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
    end
  end

  // Reset wins over a store that would commit on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (w_mem_we) begin
      mem_q[w_acc_idx] <= w_acc_wdata;
    end
  end

  assign bus.req_ready  = (state_q == c_ST_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_error = resp_error_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dmem_responder : directed checks for dmem_responder at LATENCY 2 and 1
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_dmem_responder;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if a_if ();
  dmem_responder_if b_if ();

  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(2)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if.slave)
  );

  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction on the LATENCY=2 instance; hold = stall cycles.
  task automatic txn_a(input logic w, input logic [31:0] ad, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int hold, input string tag, output int t_acc);
    int n;
    a_if.req_valid = 1'b1;
    a_if.req_write = w;
    a_if.req_addr  = ad;
    a_if.req_wdata = wd;
    chk({tag, ".req_ready"}, 32'(a_if.req_ready), 32'd1);
    @(negedge clk);
    t_acc = cyc;
    a_if.req_valid = 1'b0;
    a_if.req_write = ~w;
    a_if.req_addr  = 32'hFFFF_FFFF;
    a_if.req_wdata = 32'hFFFF_FFFF;
    n = 0;
    while (a_if.resp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, 32'(n), 32'd2);
    chk({tag, ".rdata"}, a_if.resp_rdata, exp_rd);
    chk({tag, ".error"}, 32'(a_if.resp_error), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(a_if.resp_valid), 32'd1);
      chk({tag, ".hold_rdata"}, a_if.resp_rdata, exp_rd);
      chk({tag, ".hold_error"}, 32'(a_if.resp_error), 32'(exp_err));
      chk({tag, ".hold_ready"}, 32'(a_if.req_ready), 32'd0);
    end
    a_if.resp_ready = 1'b1;
    @(negedge clk);
    a_if.resp_ready = 1'b0;
    chk({tag, ".drop_valid"}, 32'(a_if.resp_valid), 32'd0);
    chk({tag, ".idle_ready"}, 32'(a_if.req_ready), 32'd1);
  endtask

  initial begin
    int t1;
    int t2;
    int n;
    int acc;
    logic [31:0] exp_q [$];
    logic [31:0] e;

    a_if.req_valid = 1'b0; a_if.req_write = 1'b0; a_if.req_addr = 32'd0;
    a_if.req_wdata = 32'd0; a_if.resp_ready = 1'b0;
    b_if.req_valid = 1'b0; b_if.req_write = 1'b0; b_if.req_addr = 32'd0;
    b_if.req_wdata = 32'd0; b_if.resp_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.a_resp_valid", 32'(a_if.resp_valid), 32'd0);
    chk("rst.a_resp_rdata", a_if.resp_rdata, 32'd0);
    chk("rst.a_resp_error", 32'(a_if.resp_error), 32'd0);
    chk("rst.b_resp_valid", 32'(b_if.resp_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst.a_req_ready", 32'(a_if.req_ready), 32'd1);
    chk("rst.b_req_ready", 32'(b_if.req_ready), 32'd1);

    // Store then load, with spacing check
    txn_a(1'b1, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0, 0, "st10", t1);
    txn_a(1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 0, "ld10", t2);
    chk("spacing_a", 32'((t2 - t1) >= 3), 32'd1);

    // Error cases; the out-of-range store must not alias onto word 0
    txn_a(1'b0, 32'h13, 32'd0, 32'd0, 1'b1, 0, "ld_misalign", t1);
    txn_a(1'b1, 32'h400, 32'hCAFE_F00D, 32'd0, 1'b1, 0, "st_range", t1);
    txn_a(1'b0, 32'h0, 32'd0, 32'd0, 1'b0, 0, "ld_word0", t1);

    // Back-pressured response
    txn_a(1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 5, "stall", t1);

    // req_valid held high with rotating addresses
    txn_a(1'b1, 32'h14, 32'h1111_1111, 32'd0, 1'b0, 0, "st14", t1);
    txn_a(1'b1, 32'h18, 32'h2222_2222, 32'd0, 1'b0, 0, "st18", t1);
    acc = 0;
    a_if.resp_ready = 1'b1;
    a_if.req_valid  = 1'b1;
    a_if.req_write  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      case (i % 3)
        0:       a_if.req_addr = 32'h10;
        1:       a_if.req_addr = 32'h14;
        default: a_if.req_addr = 32'h18;
      endcase
      if (a_if.resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("stream.spurious", 32'(a_if.resp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("stream.rdata", a_if.resp_rdata, e);
          chk("stream.error", 32'(a_if.resp_error), 32'd0);
        end
      end
      if (a_if.req_ready === 1'b1) begin
        case (i % 3)
          0:       exp_q.push_back(32'hDEAD_BEEF);
          1:       exp_q.push_back(32'h1111_1111);
          default: exp_q.push_back(32'h2222_2222);
        endcase
        acc++;
      end
      @(negedge clk);
    end
    a_if.req_valid = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      if (a_if.resp_valid === 1'b1) begin
        e = exp_q.pop_front();
        chk("stream.drain_rdata", a_if.resp_rdata, e);
      end
      @(negedge clk);
      n++;
    end
    a_if.resp_ready = 1'b0;
    chk("stream.drained", 32'(exp_q.size()), 32'd0);
    chk("stream.accepts", 32'(acc >= 2), 32'd1);
    @(negedge clk);
    chk("stream.idle", 32'(a_if.req_ready), 32'd1);

    // Reset one cycle after a store is accepted
    a_if.req_valid = 1'b1;
    a_if.req_write = 1'b1;
    a_if.req_addr  = 32'h20;
    a_if.req_wdata = 32'h1234_5678;
    chk("rstmid.req_ready", 32'(a_if.req_ready), 32'd1);
    @(negedge clk);
    a_if.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid.valid_in_rst0", 32'(a_if.resp_valid), 32'd0);
    @(negedge clk);
    chk("rstmid.valid_in_rst1", 32'(a_if.resp_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid.valid_after", 32'(a_if.resp_valid), 32'd0);
    chk("rstmid.ready_after", 32'(a_if.req_ready), 32'd1);
    txn_a(1'b0, 32'h20, 32'd0, 32'd0, 1'b0, 0, "rstmid.ld20", t1);
    txn_a(1'b0, 32'h10, 32'd0, 32'd0, 1'b0, 0, "rstmid.ld10", t1);

    // LATENCY=1 instance, resp_ready tied high
    b_if.req_valid = 1'b1;
    b_if.req_write = 1'b1;
    b_if.req_addr  = 32'h3FC;
    b_if.req_wdata = 32'hA5A5_A5A5;
    chk("lat1.st_ready", 32'(b_if.req_ready), 32'd1);
    @(negedge clk);
    t1 = cyc;
    b_if.req_write = 1'b0;
    b_if.req_wdata = 32'd0;
    chk("lat1.st_valid", 32'(b_if.resp_valid), 32'd1);
    chk("lat1.st_rdata", b_if.resp_rdata, 32'd0);
    chk("lat1.st_error", 32'(b_if.resp_error), 32'd0);
    chk("lat1.st_busy", 32'(b_if.req_ready), 32'd0);
    n = 0;
    while (b_if.req_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("lat1.ld_ready", 32'(b_if.req_ready), 32'd1);
    @(negedge clk);
    t2 = cyc;
    b_if.req_valid = 1'b0;
    chk("lat1.ld_valid", 32'(b_if.resp_valid), 32'd1);
    chk("lat1.ld_rdata", b_if.resp_rdata, 32'hA5A5_A5A5);
    chk("lat1.ld_error", 32'(b_if.resp_error), 32'd0);
    chk("lat1.spacing", 32'((t2 - t1) >= 2), 32'd1);
    @(negedge clk);
    chk("lat1.drop_valid", 32'(b_if.resp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
